// File: rtl/keypad_if.sv
// Key-event handshake bundle between the keypad scanner (master) and its consumer (slave).
interface keypad_if #(
  parameter int CODE_W = 4
);
  logic              key_valid;
  logic [CODE_W-1:0] key_code;
  logic              key_ack;
  logic              key_held;
  logic              overrun;

  modport master (output key_valid, output key_code, output key_held, output overrun, input key_ack);
  modport slave  (input key_valid, input key_code, input key_held, input overrun, output key_ack);
endinterface

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: column walk, frame-level debounce, single-key events
// with valid/ack handshake, held indication and overrun reporting.
module keypad_scanner #(
  parameter int  ROWS     = 4,
  parameter int  COLS     = 4,
  parameter int  DWELL    = 4,
  parameter int  DEBOUNCE = 3,
  localparam int CODE_W   = $clog2(ROWS * COLS)
) (
  input  logic            sclk,
  input  logic            reset,
  output logic [COLS-1:0] col_n,
  input  logic [ROWS-1:0] row_n,
  keypad_if.master        kif
);

  localparam int         COL_W   = $clog2(COLS);
  localparam int         DWELL_W = $clog2(DWELL);
  localparam logic [3:0] DEB_L   = 4'(DEBOUNCE);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PRESS_DB = 2'd1,
    ST_HELD     = 2'd2,
    ST_REL_DB   = 2'd3
  } state_t;

  // Saturating (0, 1, 2+) count of asserted rows in one column sample.
  function automatic logic [1:0] hit_count(input logic [ROWS-1:0] hits);
    logic [1:0] n;
    n = 2'd0;
    for (int r = 0; r < ROWS; r++) begin
      if (hits[r] && (n != 2'd2)) begin
        n = n + 2'd1;
      end
    end
    return n;
  endfunction

  function automatic int first_row(input logic [ROWS-1:0] hits);
    int idx;
    idx = 0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (hits[r]) begin
        idx = r;
      end
    end
    return idx;
  endfunction

  function automatic logic [1:0] sat_add(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > 3'd2) ? 2'd2 : s[1:0];
  endfunction

  logic [ROWS-1:0]    sync1_r, sync2_r;
  logic [COL_W-1:0]   col_r;
  logic [DWELL_W-1:0] dwell_r;
  logic [COLS-1:0]    col_n_r;
  logic [1:0]         acc_cnt_r;
  logic [CODE_W-1:0]  acc_code_r;
  state_t             state_r;
  logic [3:0]         dbc_r;
  logic [CODE_W-1:0]  cand_r;
  logic               key_valid_r, key_held_r, overrun_r;
  logic [CODE_W-1:0]  key_code_r;

  logic               sample_s, frame_end_s;
  logic [COL_W-1:0]   next_col_s;
  logic [1:0]         col_hits_s, tot_s;
  logic [CODE_W-1:0]  col_code_s, frame_code_s;
  logic               is_none_s, is_single_s;
  logic [3:0]         dbc_inc_s;
  logic               dbc_last_s, press_event_s;

  assign sample_s      = (dwell_r == DWELL_W'(DWELL - 1));
  assign frame_end_s   = sample_s && (col_r == COL_W'(COLS - 1));
  assign next_col_s    = (col_r == COL_W'(COLS - 1)) ? '0 : (col_r + COL_W'(1));
  assign col_hits_s    = hit_count(~sync2_r);
  assign col_code_s    = CODE_W'(first_row(~sync2_r) * COLS + int'(col_r));
  // Classification includes the column being sampled on the frame-end edge.
  assign tot_s         = sat_add(acc_cnt_r, col_hits_s);
  assign frame_code_s  = (acc_cnt_r == 2'd0) ? col_code_s : acc_code_r;
  assign is_none_s     = (tot_s == 2'd0);
  assign is_single_s   = (tot_s == 2'd1);
  assign dbc_inc_s     = dbc_r + 4'd1;
  assign dbc_last_s    = (dbc_inc_s == DEB_L);
  assign press_event_s = frame_end_s && is_single_s &&
                         (((state_r == ST_IDLE) && (DEBOUNCE == 1)) ||
                          ((state_r == ST_PRESS_DB) && (frame_code_s == cand_r) && dbc_last_s));

  // Two-flop synchroniser for the asynchronous, pulled-up row inputs.
  always_ff @(posedge sclk) begin
    if (reset) begin
      sync1_r <= '1;
      sync2_r <= '1;
    end else begin
      sync1_r <= row_n;
      sync2_r <= sync1_r;
    end
  end

  // Column walk: each column is driven low for DWELL cycles.
  always_ff @(posedge sclk) begin
    if (reset) begin
      col_r   <= '0;
      dwell_r <= '0;
      col_n_r <= ~COLS'(1);
    end else if (sample_s) begin
      dwell_r <= '0;
      col_r   <= next_col_s;
      col_n_r <= ~(COLS'(1) << next_col_s);
    end else begin
      dwell_r <= dwell_r + DWELL_W'(1);
    end
  end

  // Per-frame hit count and first-hit code.
  always_ff @(posedge sclk) begin
    if (reset) begin
      acc_cnt_r  <= 2'd0;
      acc_code_r <= '0;
    end else if (frame_end_s) begin
      acc_cnt_r  <= 2'd0;
      acc_code_r <= '0;
    end else if (sample_s) begin
      acc_cnt_r <= tot_s;
      if ((acc_cnt_r == 2'd0) && (col_hits_s != 2'd0)) begin
        acc_code_r <= col_code_s;
      end
    end
  end

  // Debounce FSM with registered event, handshake, held and overrun outputs.
  always_ff @(posedge sclk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      dbc_r       <= 4'd0;
      cand_r      <= '0;
      key_valid_r <= 1'b0;
      key_code_r  <= '0;
      key_held_r  <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      overrun_r <= 1'b0;
      if (press_event_s) begin
        if (!key_valid_r || kif.key_ack) begin
          key_valid_r <= 1'b1;
          key_code_r  <= frame_code_s;
        end else begin
          overrun_r <= 1'b1;
        end
      end else if (kif.key_ack) begin
        key_valid_r <= 1'b0;
      end

      if (frame_end_s) begin
        case (state_r)
          ST_IDLE: begin
            if (is_single_s) begin
              cand_r <= frame_code_s;
              if (DEBOUNCE == 1) begin
                state_r    <= ST_HELD;
                dbc_r      <= 4'd0;
                key_held_r <= 1'b1;
              end else begin
                state_r <= ST_PRESS_DB;
                dbc_r   <= 4'd1;
              end
            end
          end
          ST_PRESS_DB: begin
            if (!is_single_s) begin
              state_r <= ST_IDLE;
              dbc_r   <= 4'd0;
            end else if (frame_code_s != cand_r) begin
              cand_r <= frame_code_s;
              dbc_r  <= 4'd1;
            end else if (dbc_last_s) begin
              state_r    <= ST_HELD;
              dbc_r      <= 4'd0;
              key_held_r <= 1'b1;
            end else begin
              dbc_r <= dbc_inc_s;
            end
          end
          ST_HELD: begin
            if (is_none_s) begin
              if (DEBOUNCE == 1) begin
                state_r    <= ST_IDLE;
                dbc_r      <= 4'd0;
                key_held_r <= 1'b0;
              end else begin
                state_r <= ST_REL_DB;
                dbc_r   <= 4'd1;
              end
            end
          end
          ST_REL_DB: begin
            if (!is_none_s) begin
              state_r <= ST_HELD;
              dbc_r   <= 4'd0;
            end else if (dbc_last_s) begin
              state_r    <= ST_IDLE;
              dbc_r      <= 4'd0;
              key_held_r <= 1'b0;
            end else begin
              dbc_r <= dbc_inc_s;
            end
          end
          default: begin
            state_r    <= ST_IDLE;
            dbc_r      <= 4'd0;
            key_held_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign col_n         = col_n_r;
  assign kif.key_valid = key_valid_r;
  assign kif.key_code  = key_code_r;
  assign kif.key_held  = key_held_r;
  assign kif.overrun   = overrun_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a default 4x4 instance and a 3x3 single-frame-debounce instance.
module tb_keypad_scanner;

  localparam int FRAME1 = 16;

  logic        sclk;
  logic        reset;
  logic [3:0]  col_n1;
  logic [3:0]  row_n1;
  logic [2:0]  col_n2;
  logic [2:0]  row_n2;
  logic [15:0] keys1;
  logic [8:0]  keys2;
  int          cyc;
  int          n_checks;
  int          n_pass;
  int          ovr1_cnt;
  int          ovr2_cnt;
  int          exp1_q[$];
  int          exp2_q[$];

  keypad_if #(.CODE_W(4)) kif1 ();
  keypad_if #(.CODE_W(4)) kif2 ();

  keypad_scanner dut1 (
    .sclk  (sclk),
    .reset (reset),
    .col_n (col_n1),
    .row_n (row_n1),
    .kif   (kif1)
  );

  keypad_scanner #(.ROWS(3), .COLS(3), .DWELL(3), .DEBOUNCE(1)) dut2 (
    .sclk  (sclk),
    .reset (reset),
    .col_n (col_n2),
    .row_n (row_n2),
    .kif   (kif2)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  // Keypad matrix model: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row_n1 = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys1[r*4+c] && !col_n1[c]) row_n1[r] = 1'b0;
  end

  always_comb begin
    row_n2 = 3'b111;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        if (keys2[r*3+c] && !col_n2[c]) row_n2[r] = 1'b0;
  end

  always @(posedge sclk) cyc <= reset ? 0 : cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Scoreboard monitors: each accepted handshake pops the expected code.
  always @(negedge sclk) begin
    if (!reset && kif1.key_valid && kif1.key_ack) begin
      if (exp1_q.size() == 0) check("ev1_unexpected", 32'd1, 32'd0);
      else check("ev1_code", 32'(kif1.key_code), 32'(exp1_q.pop_front()));
    end
    if (!reset && kif1.overrun) ovr1_cnt <= ovr1_cnt + 1;
  end

  always @(negedge sclk) begin
    if (!reset && kif2.key_valid && kif2.key_ack) begin
      if (exp2_q.size() == 0) check("ev2_unexpected", 32'd1, 32'd0);
      else check("ev2_code", 32'(kif2.key_code), 32'(exp2_q.pop_front()));
    end
    if (!reset && kif2.overrun) ovr2_cnt <= ovr2_cnt + 1;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge sclk);
    #1;
  endtask

  task automatic next_frames(input int n);
    repeat (n) begin
      do begin
        @(posedge sclk);
        #1;
      end while ((cyc % FRAME1) != 0);
    end
  endtask

  task automatic ack1();
    kif1.key_ack = 1'b1;
    wait_cycles(1);
    kif1.key_ack = 1'b0;
    check("ack1_clears_valid", 32'(kif1.key_valid), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    ovr1_cnt = 0;
    ovr2_cnt = 0;
    reset    = 1'b1;
    keys1    = 16'h0000;
    keys2    = 9'h000;
    kif1.key_ack = 1'b0;
    kif2.key_ack = 1'b0;
    wait_cycles(3);
    check("rst_col_n", 32'(col_n1), 32'h0000000E);
    check("rst_valid", 32'(kif1.key_valid), 32'd0);
    check("rst_code", 32'(kif1.key_code), 32'd0);
    check("rst_held", 32'(kif1.key_held), 32'd0);
    check("rst_overrun", 32'(kif1.overrun), 32'd0);
    reset = 1'b0;

    // Clean press of row 1 / col 2 for five frames.
    keys1 = 16'h0040;
    exp1_q.push_back(6);
    next_frames(2);
    wait_cycles(15);
    check("clean_valid_early", 32'(kif1.key_valid), 32'd0);
    wait_cycles(1);
    check("clean_valid_rise", 32'(kif1.key_valid), 32'd1);
    check("clean_held_rise", 32'(kif1.key_held), 32'd1);
    ack1();
    next_frames(2);
    keys1 = 16'h0000;
    next_frames(2);
    wait_cycles(15);
    check("clean_held_before_fall", 32'(kif1.key_held), 32'd1);
    wait_cycles(1);
    check("clean_held_fall", 32'(kif1.key_held), 32'd0);

    // Bounce: key 5 present, absent, then present for three frames.
    keys1 = 16'h0020;
    exp1_q.push_back(5);
    next_frames(1);
    keys1 = 16'h0000;
    next_frames(1);
    keys1 = 16'h0020;
    next_frames(2);
    wait_cycles(15);
    check("bounce_no_early_event", 32'(kif1.key_valid), 32'd0);
    wait_cycles(1);
    check("bounce_valid", 32'(kif1.key_valid), 32'd1);
    ack1();
    next_frames(1);
    keys1 = 16'h0000;
    next_frames(4);

    // Multi-key: keys 0 and 15 together, then key 15 released.
    keys1 = 16'h8001;
    next_frames(10);
    check("multi_held", 32'(kif1.key_held), 32'd0);
    check("multi_valid", 32'(kif1.key_valid), 32'd0);
    keys1 = 16'h0001;
    exp1_q.push_back(0);
    next_frames(2);
    wait_cycles(15);
    check("multi_after_early", 32'(kif1.key_valid), 32'd0);
    wait_cycles(1);
    check("multi_after_valid", 32'(kif1.key_valid), 32'd1);
    ack1();
    next_frames(1);
    keys1 = 16'h0000;
    next_frames(4);

    // Overrun: key 3 left pending, then key 9 dropped.
    keys1 = 16'h0008;
    exp1_q.push_back(3);
    next_frames(3);
    check("ovr_first_valid", 32'(kif1.key_valid), 32'd1);
    keys1 = 16'h0000;
    next_frames(3);
    keys1 = 16'h0200;
    next_frames(2);
    wait_cycles(15);
    check("ovr_before", 32'(kif1.overrun), 32'd0);
    wait_cycles(1);
    check("ovr_pulse", 32'(kif1.overrun), 32'd1);
    check("ovr_code_kept", 32'(kif1.key_code), 32'd3);
    check("ovr_valid_kept", 32'(kif1.key_valid), 32'd1);
    check("ovr_held", 32'(kif1.key_held), 32'd1);
    wait_cycles(1);
    check("ovr_one_cycle", 32'(kif1.overrun), 32'd0);
    next_frames(1);
    keys1 = 16'h0000;
    next_frames(4);

    // Same press again, acked on the very edge the new event loads.
    keys1 = 16'h0200;
    exp1_q.push_back(9);
    next_frames(2);
    wait_cycles(15);
    kif1.key_ack = 1'b1;
    wait_cycles(1);
    kif1.key_ack = 1'b0;
    check("ack_load_valid", 32'(kif1.key_valid), 32'd1);
    check("ack_load_code", 32'(kif1.key_code), 32'd9);
    check("ack_load_no_ovr", 32'(kif1.overrun), 32'd0);
    ack1();
    next_frames(1);
    keys1 = 16'h0000;
    next_frames(4);

    // Reset during the second frame of press debounce.
    keys1 = 16'h0040;
    next_frames(1);
    wait_cycles(5);
    reset = 1'b1;
    wait_cycles(1);
    check("midrst_col_n", 32'(col_n1), 32'h0000000E);
    check("midrst_valid", 32'(kif1.key_valid), 32'd0);
    check("midrst_held", 32'(kif1.key_held), 32'd0);
    check("midrst_code", 32'(kif1.key_code), 32'd0);
    reset = 1'b0;
    exp1_q.push_back(6);
    wait_cycles(3);
    check("midrst_col0_dwell", 32'(col_n1), 32'h0000000E);
    wait_cycles(1);
    check("midrst_col1", 32'(col_n1), 32'h0000000D);
    wait_cycles(43);
    check("midrst_valid_early", 32'(kif1.key_valid), 32'd0);
    wait_cycles(1);
    check("midrst_valid_rise", 32'(kif1.key_valid), 32'd1);
    ack1();
    next_frames(1);
    keys1 = 16'h0000;
    next_frames(4);

    // 3x3 instance, single-frame debounce.
    reset = 1'b1;
    wait_cycles(1);
    check("p_rst_col_n", 32'(col_n2), 32'h00000006);
    check("p_rst_valid", 32'(kif2.key_valid), 32'd0);
    check("p_rst_held", 32'(kif2.key_held), 32'd0);
    keys2 = 9'h100;
    exp2_q.push_back(8);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      logic [2:0] one;
      logic [2:0] exp_col;
      one = 3'b001;
      exp_col = ~(one << ((i / 3) % 3));
      check($sformatf("p_col_n_c%0d", i), 32'(col_n2), 32'(exp_col));
      if (i == 8) check("p_valid_early", 32'(kif2.key_valid), 32'd0);
      if (i == 9) begin
        check("p_valid", 32'(kif2.key_valid), 32'd1);
        check("p_held", 32'(kif2.key_held), 32'd1);
      end
      wait_cycles(1);
    end
    kif2.key_ack = 1'b1;
    wait_cycles(1);
    kif2.key_ack = 1'b0;
    check("p_ack_clears", 32'(kif2.key_valid), 32'd0);
    keys2 = 9'h000;
    wait_cycles(20);
    check("p_held_fall", 32'(kif2.key_held), 32'd0);

    check("q1_drained", 32'(exp1_q.size()), 32'd0);
    check("q2_drained", 32'(exp2_q.size()), 32'd0);
    check("ovr1_pulses", 32'(ovr1_cnt), 32'd1);
    check("ovr2_pulses", 32'(ovr2_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
